// File: rtl/fixed_pkg.sv
// fixed_pkg: special-value codes, FSM states and flag positions shared by the fixed multiplier.
package fixed_pkg;
    localparam int MAXW = 128;
    localparam int FLAG_OVF = 1;
    localparam int FLAG_UNF = 0;
    typedef logic [MAXW-1:0] code_t;
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_NORM, S_DONE} state_t;
    function automatic code_t nan_code(input int w);
        return code_t'(1) << (w - 1);
    endfunction
    function automatic code_t pinf_code(input int w);
        return nan_code(w) - code_t'(1);
    endfunction
    function automatic code_t ninf_code(input int w);
        return nan_code(w) | code_t'(1);
    endfunction
endpackage

// File: rtl/fixed_mul_iter_if.sv
// fixed_mul_iter_if: operand and result valid/ready handshakes of the iterative multiplier.
interface fixed_mul_iter_if #(parameter int WIDTH = 64);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic [1:0]       flags;
    modport master(output in_valid, a, b, out_ready, input in_ready, out_valid, res, flags);
    modport slave(input in_valid, a, b, out_ready, output in_ready, out_valid, res, flags);
endinterface

// File: rtl/fixed_decoder.sv
// fixed_decoder: classifies a fixed-point code as NaN, infinity or zero and extracts its sign.
module fixed_decoder
    import fixed_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] i_data,
    output logic             o_sign,
    output logic             o_nan,
    output logic             o_zero,
    output logic             o_inf
);
    localparam logic [WIDTH-1:0] NAN_C  = WIDTH'(nan_code(WIDTH));
    localparam logic [WIDTH-1:0] PINF_C = WIDTH'(pinf_code(WIDTH));
    localparam logic [WIDTH-1:0] NINF_C = WIDTH'(ninf_code(WIDTH));
    assign o_sign = i_data[WIDTH-1];
    assign o_nan  = i_data == NAN_C;
    assign o_zero = i_data == '0;
    assign o_inf  = (i_data == PINF_C) || (i_data == NINF_C);
endmodule

// File: rtl/fixed_mul_iter.sv
// fixed_mul_iter: iterative signed fixed-point multiplier with specials, rounding and saturation.
module fixed_mul_iter
    import fixed_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int FRAC  = 48,
    parameter int STEP  = 2,
    parameter int ROUND = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    fixed_mul_iter_if.slave bus
);
    localparam int N  = (WIDTH - 1 + STEP - 1) / STEP;
    localparam int AW = 2 * WIDTH - 2;
    localparam int MW = N * STEP;
    localparam int CW = $clog2(N + 1);
    localparam int RW = AW - FRAC + 1;
    localparam logic [WIDTH-1:0] NAN_C  = WIDTH'(nan_code(WIDTH));
    localparam logic [WIDTH-1:0] PINF_C = WIDTH'(pinf_code(WIDTH));
    localparam logic [WIDTH-1:0] NINF_C = WIDTH'(ninf_code(WIDTH));
    localparam logic [RW-1:0]    MAXF   = RW'(PINF_C) - RW'(1);

    state_t           r_state, w_next;
    logic [CW-1:0]    r_cnt;
    logic [AW-1:0]    r_acc, r_mcand, w_add;
    logic [MW-1:0]    r_mplier;
    logic             r_neg;
    logic [WIDTH-1:0] r_res, w_nres, w_sres, w_mag;
    logic [1:0]       r_flags, w_nflags;
    logic [RW-1:0]    w_m;
    logic             w_a_sign, w_a_nan, w_a_zero, w_a_inf;
    logic             w_b_sign, w_b_nan, w_b_zero, w_b_inf;
    logic             w_accept, w_nan, w_inf, w_special;

    function automatic logic [WIDTH-2:0] mag(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] t;
        t = x[WIDTH-1] ? -x : x;
        return t[WIDTH-2:0];
    endfunction

    fixed_decoder #(.WIDTH(WIDTH)) u_dec_a (
        .i_data(bus.a), .o_sign(w_a_sign), .o_nan(w_a_nan), .o_zero(w_a_zero), .o_inf(w_a_inf)
    );
    fixed_decoder #(.WIDTH(WIDTH)) u_dec_b (
        .i_data(bus.b), .o_sign(w_b_sign), .o_nan(w_b_nan), .o_zero(w_b_zero), .o_inf(w_b_inf)
    );

    assign bus.in_ready  = (r_state == S_IDLE) && rst_n;
    assign bus.out_valid = r_state == S_DONE;
    assign bus.res       = r_res;
    assign bus.flags     = r_flags;
    assign w_accept  = bus.in_valid && bus.in_ready;
    assign w_nan     = w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero);
    assign w_inf     = w_a_inf || w_b_inf;
    assign w_special = w_nan || w_inf || w_a_zero || w_b_zero;
    assign w_sres    = w_nan ? NAN_C : w_inf ? ((w_a_sign ^ w_b_sign) ? NINF_C : PINF_C) : '0;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_accept ? (w_special ? S_DONE : S_BUSY) : S_IDLE;
            S_BUSY:  w_next = (r_cnt == CW'(N - 1)) ? S_NORM : S_BUSY;
            S_NORM:  w_next = S_DONE;
            default: w_next = bus.out_ready ? S_IDLE : S_DONE;
        endcase
    end

    // Each busy cycle adds |a| times the low STEP bits of the remaining |b|.
    always_comb begin
        w_add = '0;
        for (int k = 0; k < STEP; k++)
            w_add = r_mplier[k] ? w_add + (r_mcand << k) : w_add;
    end

    always_comb begin
        w_m      = RW'(r_acc >> FRAC) + RW'((ROUND != 0) && r_acc[FRAC-1]);
        w_mag    = w_m[WIDTH-1:0];
        w_nflags = '0;
        w_nflags[FLAG_OVF] = w_m > MAXF;
        w_nflags[FLAG_UNF] = w_m == '0;
        w_nres   = w_nflags[FLAG_OVF] ? (r_neg ? NINF_C : PINF_C) : (r_neg ? -w_mag : w_mag);
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_neg    <= 1'b0;
            r_res    <= '0;
            r_flags  <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_cnt    <= '0;
                    r_acc    <= '0;
                    r_mcand  <= AW'(mag(bus.a));
                    r_mplier <= MW'(mag(bus.b));
                    r_neg    <= w_a_sign ^ w_b_sign;
                    r_res    <= w_sres;
                    r_flags  <= '0;
                end
                S_BUSY: begin
                    r_cnt    <= r_cnt + CW'(1);
                    r_acc    <= r_acc + w_add;
                    r_mcand  <= r_mcand << STEP;
                    r_mplier <= r_mplier >> STEP;
                end
                S_NORM: begin
                    r_res   <= w_nres;
                    r_flags <= w_nflags;
                end
                default: ;
            endcase
        end
endmodule

// File: tb/tb_fixed_mul_iter.sv
// tb_fixed_mul_iter: Q15.16 checks of truncating and rounding multipliers fed identical stimulus.
module tb_fixed_mul_iter;
    localparam logic [31:0] NAN_V = 32'h80000000;
    localparam logic [31:0] PINF_V = 32'h7FFFFFFF;
    localparam logic [31:0] NINF_V = 32'h80000001;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] a, b;
    logic        in_valid, out_ready;
    int          n_chk = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    fixed_mul_iter_if #(.WIDTH(32)) i0 ();
    fixed_mul_iter_if #(.WIDTH(32)) i1 ();
    assign i0.a = a;
    assign i0.b = b;
    assign i0.in_valid = in_valid;
    assign i0.out_ready = out_ready;
    assign i1.a = a;
    assign i1.b = b;
    assign i1.in_valid = in_valid;
    assign i1.out_ready = out_ready;

    fixed_mul_iter #(.WIDTH(32), .FRAC(16), .STEP(1), .ROUND(0)) u0 (.clk(clk), .rst_n(rst_n), .bus(i0.slave));
    fixed_mul_iter #(.WIDTH(32), .FRAC(16), .STEP(1), .ROUND(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: classify operands, then exact integer product scaled by 2^-16.
    function automatic void model(input logic [31:0] x, input logic [31:0] y, input bit rnd,
                                  output logic [31:0] r, output logic [1:0] f, output bit sp);
        bit     xi, yi, xn, yn, xz, yz, neg;
        longint ax, ay, p, m;
        xi = (x == PINF_V) || (x == NINF_V);
        yi = (y == PINF_V) || (y == NINF_V);
        xn = x == NAN_V;
        yn = y == NAN_V;
        xz = x == 0;
        yz = y == 0;
        neg = x[31] ^ y[31];
        f = 2'b00;
        sp = 1'b1;
        r = 32'h0;
        if (xn || yn || (xi && yz) || (yi && xz)) r = NAN_V;
        else if (xi || yi) r = neg ? NINF_V : PINF_V;
        else if (!(xz || yz)) begin
            sp = 1'b0;
            ax = longint'(signed'(x));
            ay = longint'(signed'(y));
            if (ax < 0) ax = -ax;
            if (ay < 0) ay = -ay;
            p = ax * ay;
            m = (p >>> 16) + (rnd ? ((p >>> 15) & 64'sd1) : 64'sd0);
            if (m > 64'sd2147483646) begin
                r = neg ? NINF_V : PINF_V;
                f = 2'b10;
            end else if (m == 0) f = 2'b01;
            else r = neg ? 32'(-m) : 32'(m);
        end
    endfunction

    function automatic logic [31:0] pick();
        int          s;
        logic [31:0] v;
        s = $urandom_range(0, 15);
        v = $urandom;
        case (s)
            0: return NAN_V;
            1: return PINF_V;
            2: return NINF_V;
            3: return 32'h0;
            4, 5, 6: return v;
            default: begin
                v = v & 32'h000FFFFF;
                return $urandom_range(0, 1) ? -v : v;
            end
        endcase
    endfunction

    task automatic do_op(input logic [31:0] ta, input logic [31:0] tb, input int hold,
                         input logic [31:0] k0, input logic [31:0] k1, input bit kv);
        logic [31:0] er0, er1;
        logic [1:0]  ef0, ef1;
        bit          sp;
        int          g, lat;
        model(ta, tb, 1'b0, er0, ef0, sp);
        model(ta, tb, 1'b1, er1, ef1, sp);
        out_ready = (hold == 0);
        g = 0;
        while (!i0.in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        if (g >= 200) check("ready_timeout", 0, 1);
        @(negedge clk);
        a = ta;
        b = tb;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 1;
        while (!i0.out_valid && lat < 100) begin
            @(posedge clk);
            #1 lat++;
        end
        check("latency", 64'(lat), sp ? 64'd1 : 64'd33);
        check("valid1", i1.out_valid, 1);
        check("res0", i0.res, er0);
        check("flags0", i0.flags, ef0);
        check("res1", i1.res, er1);
        check("flags1", i1.flags, ef1);
        if (kv) begin
            check("known0", i0.res, k0);
            check("known1", i1.res, k1);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check("hold_valid", i0.out_valid, 1);
            check("hold_ready", i0.in_ready, 0);
            check("hold_res", i0.res, er0);
            check("hold_flags", i0.flags, ef0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("drop_valid", i0.out_valid, 0);
        check("rise_ready", i0.in_ready, 1);
    endtask

    initial begin
        a = 0;
        b = 0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", i0.out_valid, 0);
        check("rst_ready", i0.in_ready, 0);
        check("rst_res", i0.res, 0);
        check("rst_flags", i0.flags, 0);
        check("rst_res1", i1.res, 0);
        @(negedge clk) rst_n = 1'b1;
        #1 check("rel_ready", i0.in_ready, 1);

        do_op(32'h00018000, 32'h00020000, 0, 32'h00030000, 32'h00030000, 1);
        do_op(32'hFFFE8000, 32'h00020000, 0, 32'hFFFD0000, 32'hFFFD0000, 1);
        do_op(32'h40000000, 32'h00040000, 0, 32'h7FFFFFFF, 32'h7FFFFFFF, 1);
        do_op(32'hC0000000, 32'h00040000, 0, 32'h80000001, 32'h80000001, 1);
        do_op(32'h80000000, 32'h00000000, 0, 32'h80000000, 32'h80000000, 1);
        do_op(32'h7FFFFFFF, 32'h00000000, 0, 32'h80000000, 32'h80000000, 1);
        do_op(32'h7FFFFFFF, 32'hFFFF0000, 0, 32'h80000001, 32'h80000001, 1);
        do_op(32'h00000001, 32'h00008000, 0, 32'h00000000, 32'h00000001, 1);
        do_op(32'h00018000, 32'h00020000, 5, 32'h00030000, 32'h00030000, 1);

        @(negedge clk);
        a = 32'h00050000;
        b = 32'h00030000;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        #1;
        check("abort_valid", i0.out_valid, 0);
        check("abort_ready", i0.in_ready, 0);
        check("abort_res", i0.res, 0);
        @(negedge clk) rst_n = 1'b1;
        #1 check("abort_rel_ready", i0.in_ready, 1);
        do_op(32'h00050000, 32'h00030000, 0, 32'h000F0000, 32'h000F0000, 1);

        for (int i = 0; i < 30; i++)
            do_op(pick(), pick(), $urandom_range(0, 2) == 0 ? int'($urandom_range(1, 3)) : 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
